// File: rtl/write_through_buffer.sv
// Posted-write buffer: accepts CPU byte writes into a small FIFO, coalesces
// repeated addresses, forwards pending data to reads and drains over cs/we/ack.
module write_through_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 22,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_full,
  input  logic [AW-1:0] rd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dout,
  input  logic          mem_ack,
  output logic          empty,
  output logic          o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  // Handshake: mem_cs/mem_we rise with address/data already stable and stay
  // high, unchanged, until the first rising edge that samples mem_ack=1.
  state_t          r_state;
  state_t          w_next_state;
  logic            r_valid [DEPTH];
  logic [AW-1:0]   r_addr  [DEPTH];
  logic [DW-1:0]   r_data  [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_dout;

  logic            w_load;
  logic            w_pop;
  logic            w_co_hit;
  logic [PW-1:0]   w_co_idx;
  logic            w_alloc;
  logic [PW-1:0]   w_fwd_idx;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next_state = S_DRAIN;
      S_DRAIN: if (mem_ack)       w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_load = 1'b0;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:  w_load = (r_count != '0);
      S_DRAIN: w_pop  = mem_ack;
      default: ;
    endcase
  end

  assign mem_cs      = (r_state == S_DRAIN);
  assign mem_we      = mem_cs;
  assign mem_addr    = r_mem_addr;
  assign mem_dout    = r_mem_dout;
  assign cpu_full    = (r_count == CW'(DEPTH));
  assign empty       = (r_count == '0) && (r_state == S_IDLE);
  assign o_dbg_state = r_state;

  // The head entry is frozen once it is on the memory bus.
  always_comb begin
    w_co_hit = 1'b0;
    w_co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == cpu_addr) &&
          !((r_state == S_DRAIN) && (PW'(i) == r_head))) begin
        w_co_hit = 1'b1;
        w_co_idx = PW'(i);
      end
    end
  end

  assign w_alloc = cpu_we && !w_co_hit && !cpu_full;

  // Walk oldest to newest so the newest match is the one left standing.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    w_fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && r_valid[w_fwd_idx] && (r_addr[w_fwd_idx] == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[w_fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_mem_addr <= '0;
      r_mem_dout <= '0;
    end else begin
      if (cpu_we && w_co_hit) r_data[w_co_idx] <= cpu_din;
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= cpu_addr;
        r_data[r_tail]  <= cpu_din;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A write coalescing into the head on the load edge must reach memory.
      if (w_load) begin
        r_mem_addr <= r_addr[r_head];
        r_mem_dout <= (cpu_we && w_co_hit && (w_co_idx == r_head)) ? cpu_din : r_data[r_head];
      end
    end
  end

endmodule

// File: tb/tb_write_through_buffer.sv
// Bench for write_through_buffer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_write_through_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 22;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic          cpu_full;
  logic [AW-1:0] rd_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          mem_ack = 1'b0;
  logic          empty;
  logic          dbg_state;

  int n_chk = 0;
  int n_err = 0;

  write_through_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_full(cpu_full),
    .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_ack(mem_ack), .empty(empty), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: inputs change after the falling edge, outputs are read 1ns later.
  task automatic cyc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic ack, input logic [AW-1:0] rd);
    @(negedge clk);
    cpu_we = we; cpu_addr = a; cpu_din = d; mem_ack = ack; rd_addr = rd;
    #1;
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc(1'b0, '0, '0, 1'b1, '0);
      if (mem_cs) begin
        seen = 1;
        chk("drain_addr", mem_addr, a);
        chk("drain_data", mem_dout, d);
        chk("drain_we",   mem_we, 1);
      end
    end
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: got no mem_cs, expected write addr %0d", a);
    end
  endtask

  // Directed vector table
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          ack;
    logic [AW-1:0] rd;
    logic          cs;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdout;
    logic          full;
    logic          emp;
    logic          hit;
    logic [DW-1:0] fdata;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input int a, input int d, input logic ack, input int rd,
                     input logic cs, input int ma, input int md, input logic full,
                     input logic emp, input logic hit, input int fd);
    vec_t v;
    v.we = we; v.addr = AW'(a); v.din = DW'(d); v.ack = ack; v.rd = AW'(rd);
    v.cs = cs; v.maddr = AW'(ma); v.mdout = DW'(md); v.full = full; v.emp = emp;
    v.hit = hit; v.fdata = DW'(fd);
    vq.push_back(v);
  endtask

  // Reference model: ordered list of pending writes plus the in-flight copy.
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } ent_t;
  ent_t          mq[$];
  bit            m_drain;
  logic [AW-1:0] m_cap_addr;
  logic [DW-1:0] m_cap_data;

  task automatic model_reset();
    mq.delete(); m_drain = 0; m_cap_addr = '0; m_cap_data = '0;
  endtask

  task automatic model_check();
    logic          e_hit = 0;
    logic [DW-1:0] e_data = '0;
    foreach (mq[i]) if (mq[i].addr == rd_addr) begin e_hit = 1; e_data = mq[i].data; end
    chk("r_full",  cpu_full, mq.size() == DEPTH);
    chk("r_empty", empty, (mq.size() == 0) && !m_drain);
    chk("r_cs",    mem_cs, m_drain);
    chk("r_we",    mem_we, m_drain);
    chk("r_addr",  mem_addr, m_cap_addr);
    chk("r_dout",  mem_dout, m_cap_data);
    chk("r_hit",   fwd_hit, e_hit);
    chk("r_fdata", fwd_data, e_data);
    chk("r_state", dbg_state, m_drain);
  endtask

  task automatic model_step();
    int   found = -1;
    int   pre_size = mq.size();
    bit   alloc;
    ent_t e;
    if (cpu_we)
      foreach (mq[j]) if (mq[j].addr == cpu_addr && !(j == 0 && m_drain)) found = j;
    alloc = cpu_we && (found < 0) && (pre_size < DEPTH);
    if (cpu_we && found >= 0) mq[found].data = cpu_din;
    if (!m_drain && pre_size > 0) begin
      m_drain = 1; m_cap_addr = mq[0].addr; m_cap_data = mq[0].data;
    end else if (m_drain && mem_ack) begin
      void'(mq.pop_front()); m_drain = 0;
    end
    if (alloc) begin e.addr = cpu_addr; e.data = cpu_din; mq.push_back(e); end
  endtask

  logic [AW-1:0] pool [6];

  initial begin
    // Reset values
    #2;
    chk("rst_cs", mem_cs, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dout", mem_dout, 0);
    chk("rst_full", cpu_full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_hit", fwd_hit, 0);
    chk("rst_fdata", fwd_data, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk); rst = 1'b0;

    // Basic drain, then fill/full/drop/wrap.
    //  we  addr   din ack rd      cs addr   dout full emp hit fd
    add(1, 4,     23, 1, 4,      0, 0,     0,  0, 1, 0, 0);
    add(0, 0,     0,  1, 4,      0, 0,     0,  0, 0, 1, 23);
    add(0, 0,     0,  1, 4,      1, 4,     23, 0, 0, 1, 23);
    add(0, 0,     0,  1, 4,      0, 4,     23, 0, 1, 0, 0);
    add(1, 4,     1,  0, 0,      0, 4,     23, 0, 1, 0, 0);
    add(1, 5,     2,  0, 0,      0, 4,     23, 0, 0, 0, 0);
    add(1, 16388, 3,  0, 0,      1, 4,     1,  0, 0, 0, 0);
    add(1, 16391, 4,  0, 0,      1, 4,     1,  0, 0, 0, 0);
    add(1, 42,    5,  0, 0,      1, 4,     1,  1, 0, 0, 0);
    add(0, 0,     0,  1, 42,     1, 4,     1,  1, 0, 0, 0);
    add(0, 0,     0,  1, 16391,  0, 4,     1,  0, 0, 1, 4);
    add(0, 0,     0,  1, 0,      1, 5,     2,  0, 0, 0, 0);
    add(0, 0,     0,  1, 0,      0, 5,     2,  0, 0, 0, 0);
    add(0, 0,     0,  1, 0,      1, 16388, 3,  0, 0, 0, 0);
    add(0, 0,     0,  1, 0,      0, 16388, 3,  0, 0, 0, 0);
    add(1, 42,    6,  1, 0,      1, 16391, 4,  0, 0, 0, 0);
    add(1, 43,    7,  1, 0,      0, 16391, 4,  0, 0, 0, 0);
    add(0, 0,     0,  1, 0,      1, 42,    6,  0, 0, 0, 0);
    add(0, 0,     0,  1, 0,      0, 42,    6,  0, 0, 0, 0);
    add(0, 0,     0,  1, 0,      1, 43,    7,  0, 0, 0, 0);
    add(0, 0,     0,  1, 0,      0, 43,    7,  0, 1, 0, 0);
    foreach (vq[i]) begin
      cyc(vq[i].we, vq[i].addr, vq[i].din, vq[i].ack, vq[i].rd);
      chk("t_cs",    mem_cs,   vq[i].cs);
      chk("t_we",    mem_we,   vq[i].cs);
      chk("t_addr",  mem_addr, vq[i].maddr);
      chk("t_dout",  mem_dout, vq[i].mdout);
      chk("t_full",  cpu_full, vq[i].full);
      chk("t_empty", empty,    vq[i].emp);
      chk("t_hit",   fwd_hit,  vq[i].hit);
      chk("t_fdata", fwd_data, vq[i].fdata);
    end

    // Coalesce before the entry reaches the bus (lands on the load edge).
    cyc(1, 5, 10, 0, 0);
    cyc(1, 5, 77, 0, 0);
    cyc(1, 42, 1, 0, 0);
    cyc(0, 0, 0, 0, 5);
    chk("co1_cs", mem_cs, 1);
    chk("co1_addr", mem_addr, 5);
    chk("co1_dout", mem_dout, 77);
    chk("co1_fwd", fwd_data, 77);
    expect_write(5, 77);
    expect_write(42, 1);
    cyc(0, 0, 0, 1, 0);
    chk("co1_empty", empty, 1);

    // Same address while it is draining: allocates a third entry.
    cyc(1, 5, 10, 0, 0);
    cyc(1, 42, 1, 0, 0);
    cyc(1, 5, 77, 0, 0);
    cyc(0, 0, 0, 0, 5);
    chk("co2_dout", mem_dout, 10);
    chk("co2_hit", fwd_hit, 1);
    chk("co2_fwd", fwd_data, 77);
    expect_write(5, 10);
    expect_write(42, 1);
    expect_write(5, 77);
    cyc(0, 0, 0, 1, 0);
    chk("co2_empty", empty, 1);

    // Forwarding: newest of two entries wins, head included.
    cyc(1, 16388, 9, 0, 0);
    cyc(0, 0, 0, 0, 16388);
    chk("fw_head_hit", fwd_hit, 1);
    chk("fw_head_data", fwd_data, 9);
    cyc(1, 16388, 12, 0, 0);
    cyc(0, 0, 0, 0, 16388);
    chk("fw_hit", fwd_hit, 1);
    chk("fw_data", fwd_data, 12);
    cyc(0, 0, 0, 0, 43);
    chk("fw_miss_hit", fwd_hit, 0);
    chk("fw_miss_data", fwd_data, 0);
    expect_write(16388, 9);
    expect_write(16388, 12);

    // Push in the same edge as a pop from a full buffer is refused.
    cyc(1, 1, 11, 0, 0);
    cyc(1, 2, 12, 0, 0);
    cyc(1, 3, 13, 0, 0);
    cyc(1, 4, 14, 0, 0);
    cyc(1, 43, 50, 1, 0);
    chk("pp_full", cpu_full, 1);
    chk("pp_cs", mem_cs, 1);
    cyc(1, 43, 51, 0, 0);
    chk("pp_after", cpu_full, 0);
    cyc(0, 0, 0, 0, 43);
    chk("pp_refull", cpu_full, 1);
    chk("pp_fwd", fwd_data, 51);
    expect_write(2, 12);
    expect_write(3, 13);
    expect_write(4, 14);
    expect_write(43, 51);

    // Asynchronous reset while a write is on the bus.
    cyc(1, 7, 7, 0, 0);
    cyc(0, 0, 0, 0, 7);
    cyc(0, 0, 0, 0, 7);
    chk("ar_cs_before", mem_cs, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_cs", mem_cs, 0);
    chk("ar_empty", empty, 1);
    chk("ar_hit", fwd_hit, 0);
    chk("ar_addr", mem_addr, 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1, 7);
      chk("ar_idle_cs", mem_cs, 0);
      chk("ar_idle_empty", empty, 1);
    end

    // Randomized run against the reference model.
    pool[0] = 3; pool[1] = 7; pool[2] = 16388; pool[3] = 42; pool[4] = 5; pool[5] = 100;
    model_reset();
    for (int k = 0; k < 1500; k++) begin
      cyc(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)], DW'($urandom),
          1'($urandom_range(0, 2) == 0), pool[$urandom_range(0, 5)]);
      model_check();
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
